// File: rtl/ad9361_spi_bridge.sv
// Avalon-MM-style single-byte register responder driving an AD9361 4-wire SPI port.
// Each access is one 24-bit mode-0 frame: 16-bit instruction then 8-bit data, MSB first.
module ad9361_spi_bridge #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       read,
    input  logic       write,
    input  logic [9:0] address,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    output logic       waitrequest,
    output logic       spi_csn,
    output logic       spi_clk,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [DW-1:0] r_div;
    logic [4:0]  r_bit;
    logic        r_high;
    logic [23:0] r_sr;
    logic [7:0]  r_rx;
    logic        r_rd;
    logic [7:0]  r_readdata;
    logic        r_wait;
    logic        r_csn;
    logic        r_sclk;
    logic        r_mosi;

    logic        w_div_end;
    logic [23:0] w_frame;

    assign w_div_end = (r_div == DIV_LAST);
    // Instruction: R/W bit, byte count 0 (= 1 byte), two reserved bits, 10-bit address.
    assign w_frame   = {write, 3'b000, 2'b00, address, write ? writedata : 8'h00};

    assign readdata    = r_readdata;
    assign waitrequest = r_wait;
    assign spi_csn     = r_csn;
    assign spi_clk     = r_sclk;
    assign spi_mosi    = r_mosi;

    // NOTE: every SPI pin and waitrequest is a flop, so the device never sees glitches;
    // state is updated with <= only, and the async reset drops the frame immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_bit      <= '0;
            r_high     <= 1'b0;
            r_sr       <= '0;
            r_rx       <= '0;
            r_rd       <= 1'b0;
            r_readdata <= 8'h00;
            r_wait     <= 1'b1;
            r_csn      <= 1'b1;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
        end else begin
            // Divider wraps exactly when a phase ends, so each state starts from zero.
            r_div <= w_div_end ? '0 : r_div + 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_div <= '0;
                    if (read || write) begin
                        r_sr    <= w_frame;
                        r_rd    <= ~write;
                        r_mosi  <= w_frame[23];
                        r_csn   <= 1'b0;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (w_div_end) begin
                        r_bit   <= '0;
                        r_high  <= 1'b0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_div_end) begin
                        if (!r_high) begin
                            r_high <= 1'b1;
                            r_sclk <= 1'b1;
                            // Only rising edges 17..24 carry read data.
                            if (r_bit >= 5'd16) begin
                                r_rx <= {r_rx[6:0], spi_miso};
                            end
                        end else begin
                            r_high <= 1'b0;
                            r_sclk <= 1'b0;
                            r_sr   <= {r_sr[22:0], 1'b0};
                            r_mosi <= r_sr[22];
                            if (r_bit == 5'd23) begin
                                r_state <= S_HOLD;
                            end else begin
                                r_bit <= r_bit + 5'd1;
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (w_div_end) begin
                        r_csn   <= 1'b1;
                        r_mosi  <= 1'b0;
                        r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (w_div_end) begin
                        r_wait  <= 1'b0;
                        if (r_rd) begin
                            r_readdata <= r_rx;
                        end
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_div   <= '0;
                    r_wait  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ad9361_spi_bridge.sv
// Directed bench for ad9361_spi_bridge: one instance at CLK_DIV=2, one at CLK_DIV=4,
// each with a mode-0 slave model that records MOSI and returns a programmed byte.
module tb_ad9361_spi_bridge;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] b_read = '0;
    logic [1:0] b_write = '0;
    logic [9:0] b_addr [2];
    logic [7:0] b_wdata [2];

    logic [7:0] rdata2, rdata4;
    logic       wait2, wait4, csn2, csn4, sclk2, sclk4, mosi2, mosi4;
    logic       miso2, miso4;

    logic [23:0] cap2, cap4;
    int          cnt2, cnt4;
    logic [7:0]  byte2, byte4;

    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;

    int   t_n, t_csn_low, t_hmin, t_hmax, t_pmin, t_pmax, t_rise, t_fall;
    logic t_to, t_wait_after;
    logic [7:0] t_rdata;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ad9361_spi_bridge #(.CLK_DIV(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .read(b_read[0]), .write(b_write[0]),
        .address(b_addr[0]), .writedata(b_wdata[0]), .readdata(rdata2),
        .waitrequest(wait2), .spi_csn(csn2), .spi_clk(sclk2),
        .spi_mosi(mosi2), .spi_miso(miso2)
    );

    ad9361_spi_bridge #(.CLK_DIV(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .read(b_read[1]), .write(b_write[1]),
        .address(b_addr[1]), .writedata(b_wdata[1]), .readdata(rdata4),
        .waitrequest(wait4), .spi_csn(csn4), .spi_clk(sclk4),
        .spi_mosi(mosi4), .spi_miso(miso4)
    );

    // Slave models: clear on CS assertion, capture MOSI on each rising SCLK.
    always @(negedge csn2 or posedge sclk2) begin
        if (sclk2) begin
            cap2 <= {cap2[22:0], mosi2};
            cnt2 <= cnt2 + 1;
        end else begin
            cap2 <= '0;
            cnt2 <= 0;
        end
    end

    always @(negedge csn4 or posedge sclk4) begin
        if (sclk4) begin
            cap4 <= {cap4[22:0], mosi4};
            cnt4 <= cnt4 + 1;
        end else begin
            cap4 <= '0;
            cnt4 <= 0;
        end
    end

    // Data-phase bit for the next rising edge; 1s during the instruction phase.
    always_comb begin
        miso2 = 1'b1;
        if (cnt2 >= 16 && cnt2 < 24) miso2 = byte2[23 - cnt2];
    end

    always_comb begin
        miso4 = 1'b1;
        if (cnt4 >= 16 && cnt4 < 24) miso4 = byte4[23 - cnt4];
    end

    function automatic logic s_wait(input int k);
        return (k == 0) ? wait2 : wait4;
    endfunction
    function automatic logic s_csn(input int k);
        return (k == 0) ? csn2 : csn4;
    endfunction
    function automatic logic s_sclk(input int k);
        return (k == 0) ? sclk2 : sclk4;
    endfunction
    function automatic logic [7:0] s_rdata(input int k);
        return (k == 0) ? rdata2 : rdata4;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request and follow it to the cycle after completion.
    task automatic xfer(input int k, input logic rd, input logic wr,
                        input logic [9:0] a, input logic [7:0] d,
                        input logic keep, input logic [9:0] a2, input logic [7:0] d2);
        int   n, hrun, last_rise;
        logic prev_csn, prev_sclk;
        b_read[k]  = rd;
        b_write[k] = wr;
        b_addr[k]  = a;
        b_wdata[k] = d;
        n = 0; hrun = 0; last_rise = -1;
        prev_csn = 1'b1; prev_sclk = 1'b0;
        t_csn_low = 0; t_hmin = 9999; t_hmax = 0; t_pmin = 9999; t_pmax = 0; t_to = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            n++;
            if (!s_csn(k)) begin
                t_csn_low++;
                if (prev_csn) t_fall = cyc;
            end else if (!prev_csn) begin
                t_rise = cyc;
            end
            if (s_sclk(k)) begin
                hrun++;
                if (!prev_sclk) begin
                    if (last_rise >= 0) begin
                        if (n - last_rise < t_pmin) t_pmin = n - last_rise;
                        if (n - last_rise > t_pmax) t_pmax = n - last_rise;
                    end
                    last_rise = n;
                end
            end else if (prev_sclk) begin
                if (hrun < t_hmin) t_hmin = hrun;
                if (hrun > t_hmax) t_hmax = hrun;
                hrun = 0;
            end
            prev_csn  = s_csn(k);
            prev_sclk = s_sclk(k);
            if (!s_wait(k)) break;
            if (n >= 4000) begin
                t_to = 1'b1;
                break;
            end
        end
        t_n = n;
        t_rdata = s_rdata(k);
        if (keep) begin
            b_addr[k]  = a2;
            b_wdata[k] = d2;
        end else begin
            b_read[k]  = 1'b0;
            b_write[k] = 1'b0;
        end
        @(posedge clk);
        #1;
        t_wait_after = s_wait(k);
        check("timeout", {31'd0, t_to}, 32'd0);
    endtask

    initial begin
        int r1;
        b_addr[0] = '0; b_addr[1] = '0; b_wdata[0] = '0; b_wdata[1] = '0;
        byte2 = 8'h00; byte4 = 8'h00;

        // Reset values while rst_n is held low
        #12;
        check("rst_wait", {31'd0, wait2}, 32'd1);
        check("rst_csn", {31'd0, csn2}, 32'd1);
        check("rst_sclk", {31'd0, sclk2}, 32'd0);
        check("rst_mosi", {31'd0, mosi2}, 32'd0);
        check("rst_rdata", {24'd0, rdata2}, 32'h00);
        check("rst_csn4", {31'd0, csn4}, 32'd1);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Write 0x3DF <= 0x01 at CLK_DIV=2
        xfer(0, 1'b0, 1'b1, 10'h3DF, 8'h01, 1'b0, '0, '0);
        check("wr_frame", {8'd0, cap2}, 32'h0083DF01);
        check("wr_edges", cnt2, 24);
        check("wr_rdata", {24'd0, t_rdata}, 32'h00);
        check("wr_latency", t_n, 103);
        check("wr_wait_pulse", {31'd0, t_wait_after}, 32'd1);

        // Read 0x037, slave returns 0x08
        byte2 = 8'h08;
        xfer(0, 1'b1, 1'b0, 10'h037, 8'hFF, 1'b0, '0, '0);
        check("rd_frame", {8'd0, cap2}, 32'h00003700);
        check("rd_data", {24'd0, t_rdata}, 32'h08);
        check("rd_wait_pulse", {31'd0, t_wait_after}, 32'd1);
        check("rd_csn_low", t_csn_low, 100);

        // Read and write both high: write wins, readdata unchanged
        byte2 = 8'h77;
        xfer(0, 1'b1, 1'b1, 10'h015, 8'hA5, 1'b0, '0, '0);
        check("both_frame", {8'd0, cap2}, 32'h008015A5);
        check("both_rdata", {24'd0, t_rdata}, 32'h08);

        // Write held high across two completions
        xfer(0, 1'b0, 1'b1, 10'h123, 8'h5A, 1'b1, 10'h0AB, 8'hC3);
        check("b2b_frame1", {8'd0, cap2}, 32'h0081235A);
        check("b2b_pulse1", {31'd0, t_wait_after}, 32'd1);
        r1 = t_rise;
        xfer(0, 1'b0, 1'b1, 10'h0AB, 8'hC3, 1'b0, '0, '0);
        check("b2b_frame2", {8'd0, cap2}, 32'h0080ABC3);
        check("b2b_latency2", t_n, 103);
        check("b2b_gap_ok", {31'd0, (t_fall - r1) >= 4}, 32'd1);
        check("b2b_pulse2", {31'd0, t_wait_after}, 32'd1);

        // CLK_DIV=4 read timing
        byte4 = 8'hA3;
        xfer(1, 1'b1, 1'b0, 10'h100, 8'h00, 1'b0, '0, '0);
        check("d4_latency", t_n, 205);
        check("d4_csn_low", t_csn_low, 200);
        check("d4_high_min", t_hmin, 4);
        check("d4_high_max", t_hmax, 4);
        check("d4_period_min", t_pmin, 8);
        check("d4_period_max", t_pmax, 8);
        check("d4_frame", {8'd0, cap4}, 32'h00010000);
        check("d4_edges", cnt4, 24);
        check("d4_rdata", {24'd0, t_rdata}, 32'hA3);

        // Asynchronous reset in the middle of SHIFT
        byte2 = 8'h5C;
        b_read[0] = 1'b1;
        b_addr[0] = 10'h2A6;
        repeat (30) @(posedge clk);
        #1;
        check("mid_csn_active", {31'd0, csn2}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_csn", {31'd0, csn2}, 32'd1);
        check("arst_sclk", {31'd0, sclk2}, 32'd0);
        check("arst_wait", {31'd0, wait2}, 32'd1);
        check("arst_rdata", {24'd0, rdata2}, 32'h00);
        b_read[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_idle_csn", {31'd0, csn2}, 32'd1);
        check("post_rst_idle_wait", {31'd0, wait2}, 32'd1);

        xfer(0, 1'b1, 1'b0, 10'h2A6, 8'h00, 1'b0, '0, '0);
        check("post_rst_frame", {8'd0, cap2}, 32'h0002A600);
        check("post_rst_rdata", {24'd0, t_rdata}, 32'h5C);
        check("post_rst_latency", t_n, 103);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
